// File: rtl/rv_iommu_axi4_bc_err_resp.sv
// AXI4 error responder for requests flagged by the 4-KiB boundary checker.
// Optional per-channel saturating error counters under `RV_IOMMU_BC_ERR_CNT_EN.
module rv_iommu_axi4_bc_err_resp #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter logic [1:0]  RESP_VAL   = 2'b10
`ifdef RV_IOMMU_BC_ERR_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_err_valid_i,
    output logic                  rd_err_ready_o,
    input  logic [ID_WIDTH-1:0]   rd_err_id_i,
    input  logic [7:0]            rd_err_len_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    input  logic                  wr_err_valid_i,
    output logic                  wr_err_ready_o,
    input  logic [ID_WIDTH-1:0]   wr_err_id_i,
    input  logic                  w_valid_i,
    input  logic                  w_last_i,
    output logic                  w_ready_o,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o
`ifdef RV_IOMMU_BC_ERR_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_err_cnt_o,
    output logic [CNT_WIDTH-1:0]  wr_err_cnt_o
`endif
);

    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_BEATS = 1'b1;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DRAIN = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    logic [0:0]          r_rd_state, w_rd_state_nxt;
    logic [ID_WIDTH-1:0] r_rd_id, w_rd_id_nxt;
    logic [7:0]          r_beat_cnt, w_beat_cnt_nxt;

    logic [1:0]          r_wr_state, w_wr_state_nxt;
    logic [ID_WIDTH-1:0] r_wr_id, w_wr_id_nxt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_state <= R_IDLE;
            r_rd_id    <= '0;
            r_beat_cnt <= '0;
            r_wr_state <= W_IDLE;
            r_wr_id    <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_id    <= w_rd_id_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_wr_state <= w_wr_state_nxt;
            r_wr_id    <= w_wr_id_nxt;
        end
    end

    // Read path: beat_cnt holds beats remaining after the current one.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_id_nxt    = r_rd_id;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_rd_state)
            R_IDLE: begin
                if (rd_err_valid_i) begin
                    w_rd_state_nxt = R_BEATS;
                    w_rd_id_nxt    = rd_err_id_i;
                    w_beat_cnt_nxt = rd_err_len_i;
                end
            end
            R_BEATS: begin
                if (r_ready_i) begin
                    if (r_beat_cnt == 8'd0) begin
                        w_rd_state_nxt = R_IDLE;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt - 8'd1;
                    end
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    // Write path: burst length is ignored, only WLAST ends the drain.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_id_nxt    = r_wr_id;
        case (r_wr_state)
            W_IDLE: begin
                if (wr_err_valid_i) begin
                    w_wr_state_nxt = W_DRAIN;
                    w_wr_id_nxt    = wr_err_id_i;
                end
            end
            W_DRAIN: begin
                if (w_valid_i && w_last_i) begin
                    w_wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (b_ready_i) begin
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    assign rd_err_ready_o = (r_rd_state == R_IDLE);
    assign r_valid_o      = (r_rd_state == R_BEATS);
    assign r_id_o         = r_rd_id;
    assign r_data_o       = '0;
    assign r_resp_o       = (r_rd_state == R_BEATS) ? RESP_VAL : 2'b00;
    assign r_last_o       = (r_rd_state == R_BEATS) && (r_beat_cnt == 8'd0);

    assign wr_err_ready_o = (r_wr_state == W_IDLE);
    assign w_ready_o      = (r_wr_state == W_DRAIN);
    assign b_valid_o      = (r_wr_state == W_RESP);
    assign b_id_o         = r_wr_id;
    assign b_resp_o       = (r_wr_state == W_RESP) ? RESP_VAL : 2'b00;

`ifdef RV_IOMMU_BC_ERR_CNT_EN
    logic                 w_rd_acc, w_wr_acc;
    logic [CNT_WIDTH-1:0] r_rd_cnt, r_wr_cnt;

    assign w_rd_acc = rd_err_valid_i && (r_rd_state == R_IDLE);
    assign w_wr_acc = wr_err_valid_i && (r_wr_state == W_IDLE);

    // Saturating counters of accepted error requests.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_acc && (r_rd_cnt != {CNT_WIDTH{1'b1}})) begin
                r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
            end
            if (w_wr_acc && (r_wr_cnt != {CNT_WIDTH{1'b1}})) begin
                r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign rd_err_cnt_o = r_rd_cnt;
    assign wr_err_cnt_o = r_wr_cnt;
`endif

endmodule

// File: tb/tb_rv_iommu_axi4_bc_err_resp.sv
// Self-checking bench for rv_iommu_axi4_bc_err_resp: beat-level model plus directed literal checks.
module tb_rv_iommu_axi4_bc_err_resp;

    localparam int unsigned IDW = 4;
    localparam int unsigned DW  = 64;
    localparam int unsigned CW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_valid, rd_ready;
    logic [IDW-1:0] rd_id;
    logic [7:0]    rd_len;
    logic          r_valid, r_ready, r_last;
    logic [IDW-1:0] r_id;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic          wr_valid, wr_ready;
    logic [IDW-1:0] wr_id;
    logic          w_valid, w_last, w_ready;
    logic          b_valid, b_ready;
    logic [IDW-1:0] b_id;
    logic [1:0]    b_resp;
`ifdef RV_IOMMU_BC_ERR_CNT_EN
    logic [CW-1:0] rd_cnt, wr_cnt;
`endif

    rv_iommu_axi4_bc_err_resp #(
        .ID_WIDTH   (IDW),
        .DATA_WIDTH (DW),
        .RESP_VAL   (2'b10)
`ifdef RV_IOMMU_BC_ERR_CNT_EN
        ,
        .CNT_WIDTH  (CW)
`endif
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .rd_err_valid_i (rd_valid),
        .rd_err_ready_o (rd_ready),
        .rd_err_id_i    (rd_id),
        .rd_err_len_i   (rd_len),
        .r_valid_o      (r_valid),
        .r_ready_i      (r_ready),
        .r_id_o         (r_id),
        .r_data_o       (r_data),
        .r_resp_o       (r_resp),
        .r_last_o       (r_last),
        .wr_err_valid_i (wr_valid),
        .wr_err_ready_o (wr_ready),
        .wr_err_id_i    (wr_id),
        .w_valid_i      (w_valid),
        .w_last_i       (w_last),
        .w_ready_o      (w_ready),
        .b_valid_o      (b_valid),
        .b_ready_i      (b_ready),
        .b_id_o         (b_id),
        .b_resp_o       (b_resp)
`ifdef RV_IOMMU_BC_ERR_CNT_EN
        ,
        .rd_err_cnt_o   (rd_cnt),
        .wr_err_cnt_o   (wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: beats still owed on R, and where the write transaction stands.
    int            m_rd_left = 0;
    logic [IDW-1:0] m_rd_id  = '0;
    bit            m_w_drain = 1'b0;
    bit            m_b_pend  = 1'b0;
    logic [IDW-1:0] m_wr_id  = '0;
    int            m_rd_acc  = 0;
    int            m_wr_acc  = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rd_left = 0;
            m_w_drain = 1'b0;
            m_b_pend  = 1'b0;
            m_rd_acc  = 0;
            m_wr_acc  = 0;
        end else begin
            if (m_rd_left > 0) begin
                if (r_ready) m_rd_left = m_rd_left - 1;
            end else if (rd_valid) begin
                m_rd_left = int'(rd_len) + 1;
                m_rd_id   = rd_id;
                m_rd_acc  = m_rd_acc + 1;
            end
            if (m_b_pend) begin
                if (b_ready) m_b_pend = 1'b0;
            end else if (m_w_drain) begin
                if (w_valid && w_last) begin
                    m_w_drain = 1'b0;
                    m_b_pend  = 1'b1;
                end
            end else if (wr_valid) begin
                m_w_drain = 1'b1;
                m_wr_id   = wr_id;
                m_wr_acc  = m_wr_acc + 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rd_ready", 64'(rd_ready), 64'(m_rd_left == 0));
            chk("m_r_valid", 64'(r_valid), 64'(m_rd_left > 0));
            if (m_rd_left > 0) begin
                chk("m_r_id", 64'(r_id), 64'(m_rd_id));
                chk("m_r_last", 64'(r_last), 64'(m_rd_left == 1));
                chk("m_r_resp", 64'(r_resp), 64'(2'b10));
                chk("m_r_data", r_data, 64'd0);
            end
            chk("m_wr_ready", 64'(wr_ready), 64'(!m_w_drain && !m_b_pend));
            chk("m_w_ready", 64'(w_ready), 64'(m_w_drain));
            chk("m_b_valid", 64'(b_valid), 64'(m_b_pend));
            if (m_b_pend) begin
                chk("m_b_id", 64'(b_id), 64'(m_wr_id));
                chk("m_b_resp", 64'(b_resp), 64'(2'b10));
            end
`ifdef RV_IOMMU_BC_ERR_CNT_EN
            chk("m_rd_cnt", 64'(rd_cnt), 64'((m_rd_acc > 3) ? 3 : m_rd_acc));
            chk("m_wr_cnt", 64'(wr_cnt), 64'((m_wr_acc > 3) ? 3 : m_wr_acc));
`endif
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        rd_valid = 1'b0; rd_id = '0; rd_len = '0; r_ready = 1'b0;
        wr_valid = 1'b0; wr_id = '0; w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        rst_n = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_r_last", 64'(r_last), 64'd0);
        chk("rst_w_ready", 64'(w_ready), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_rd_ready", 64'(rd_ready), 64'd1);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_ids", 64'({r_id, b_id}), 64'd0);
        chk("rst_resp", 64'({r_resp, b_resp}), 64'd0);
        next_cycle();

        // T1: ARLEN=3, id=5, r_ready high
        rd_valid = 1'b1; rd_id = 4'd5; rd_len = 8'd3; r_ready = 1'b1;
        @(negedge clk);
        chk("t1_accept_ready", 64'(rd_ready), 64'd1);
        next_cycle();
        rd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t1_r_valid", 64'(r_valid), 64'd1);
            chk("t1_r_id", 64'(r_id), 64'd5);
            chk("t1_r_last", 64'(r_last), 64'(k == 4));
            chk("t1_rd_ready_busy", 64'(rd_ready), 64'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("t1_done_ready", 64'(rd_ready), 64'd1);
        chk("t1_done_valid", 64'(r_valid), 64'd0);
        next_cycle();

        // T2: ARLEN=0, stalled three cycles
        rd_valid = 1'b1; rd_id = 4'd2; rd_len = 8'd0; r_ready = 1'b0;
        next_cycle();
        rd_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t2_hold_valid", 64'(r_valid), 64'd1);
            chk("t2_hold_last", 64'(r_last), 64'd1);
            chk("t2_hold_id", 64'(r_id), 64'd2);
            next_cycle();
        end
        r_ready = 1'b1;
        @(negedge clk);
        chk("t2_c4_valid", 64'(r_valid), 64'd1);
        next_cycle();
        r_ready = 1'b0;
        @(negedge clk);
        chk("t2_c5_valid", 64'(r_valid), 64'd0);
        next_cycle();

        // T3: write id=3, W at cycles 2 and 4, b_ready from cycle 7
        wr_valid = 1'b1; wr_id = 4'd3; w_valid = 1'b1;
        @(negedge clk);
        chk("t3_stall_w_idle", 64'(w_ready), 64'd0);
        next_cycle();
        wr_valid = 1'b0; w_valid = 1'b0;
        @(negedge clk);
        chk("t3_c1_w_ready", 64'(w_ready), 64'd1);
        next_cycle();
        w_valid = 1'b1;
        next_cycle();
        w_valid = 1'b0;
        next_cycle();
        w_valid = 1'b1; w_last = 1'b1;
        @(negedge clk);
        chk("t3_c4_w_ready", 64'(w_ready), 64'd1);
        next_cycle();
        w_valid = 1'b0; w_last = 1'b0;
        for (int k = 5; k <= 7; k++) begin
            if (k == 7) b_ready = 1'b1;
            @(negedge clk);
            chk("t3_b_valid", 64'(b_valid), 64'd1);
            chk("t3_b_id", 64'(b_id), 64'd3);
            chk("t3_b_resp", 64'(b_resp), 64'd2);
            chk("t3_b_w_ready", 64'(w_ready), 64'd0);
            next_cycle();
        end
        b_ready = 1'b0;
        @(negedge clk);
        chk("t3_c8_idle", 64'({wr_ready, b_valid}), 64'b10);
        next_cycle();

        // T4: concurrent read ARLEN=1 and write
        rd_valid = 1'b1; rd_id = 4'd9; rd_len = 8'd1; wr_valid = 1'b1; wr_id = 4'd6;
        next_cycle();
        rd_valid = 1'b0; wr_valid = 1'b0;
        w_valid = 1'b1;                            // cycle 1
        next_cycle();
        w_valid = 1'b0; r_ready = 1'b1;            // cycle 2
        next_cycle();
        r_ready = 1'b0; w_valid = 1'b1; w_last = 1'b1;  // cycle 3
        @(negedge clk);
        chk("t4_c3_r_last", 64'({r_valid, r_last}), 64'b11);
        next_cycle();
        w_valid = 1'b0; w_last = 1'b0; r_ready = 1'b1;  // cycle 4
        @(negedge clk);
        chk("t4_c4_b_valid", 64'({b_valid, r_valid}), 64'b11);
        next_cycle();
        r_ready = 1'b0; b_ready = 1'b1;            // cycle 5
        @(negedge clk);
        chk("t4_c5_rd_idle", 64'({rd_ready, b_valid, b_id}), {58'd0, 1'b1, 1'b1, 4'd6});
        next_cycle();
        b_ready = 1'b0;                            // cycle 6
        @(negedge clk);
        chk("t4_c6_both_idle", 64'({rd_ready, wr_ready, r_valid, b_valid}), 64'b1100);
        next_cycle();

        // T5: reset after beat 2 of an ARLEN=7 burst
        rd_valid = 1'b1; rd_id = 4'd7; rd_len = 8'd7; r_ready = 1'b1;
        next_cycle();
        rd_valid = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;                              // cycle 3
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_r_valid", 64'(r_valid), 64'd0);
        chk("t5_rd_ready", 64'(rd_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            chk("t5_no_beats", 64'(r_valid), 64'd0);
        end
        r_ready = 1'b0;
        next_cycle();

`ifdef RV_IOMMU_BC_ERR_CNT_EN
        // T6: saturating counters with CNT_WIDTH=2
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            rd_valid = 1'b1; rd_len = 8'd0; rd_id = 4'(n); r_ready = 1'b1;
            next_cycle();
            rd_valid = 1'b0;
            next_cycle();
            next_cycle();
        end
        r_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            wr_valid = 1'b1; wr_id = 4'(n + 1);
            next_cycle();
            wr_valid = 1'b0; w_valid = 1'b1; w_last = 1'b1; b_ready = 1'b1;
            next_cycle();
            w_valid = 1'b0; w_last = 1'b0;
            next_cycle();
            b_ready = 1'b0;
            next_cycle();
        end
        @(negedge clk);
        chk("t6_rd_cnt", 64'(rd_cnt), 64'd3);
        chk("t6_wr_cnt", 64'(wr_cnt), 64'd2);
        next_cycle();
`endif

        idle_inputs();
        next_cycle();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
